frame_sender: RTL and testbench

Transmit-side counterpart to the byte-command watcher on the UART receive path.
- The active module buffers result bytes here and then requests a send.
- The block frames them as header (current state/module id), length, payload and optional checksum.
- It feeds them one byte at a time to the UART transmitter via a start/busy handshake.
- It pulses `done` when the last byte has been accepted by the transmitter, so the owner can release the shared state.

---
 rtl/frame_pkg.sv | 25 ++
 rtl/byte_fifo.sv | 56 +++++
 rtl/frame_sender.sv | 170 +++++++++++++++++
 tb/tb_frame_sender.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared types and helpers for the frame sender.
// Build option: FRAME_CHECKSUM_EN adds a trailing XOR checksum byte and its FSM state.
package frame_pkg;

    // Header value meaning "no module active"
    localparam logic [7:0] IDLE_ID_DEFAULT = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_LENGTH,
        ST_PAYLOAD,
`ifdef FRAME_CHECKSUM_EN
        ST_CHECKSUM,
`endif
        ST_WAIT,
        ST_DONE
    } frame_state_t;

    // Running 8-bit XOR used to build the checksum
    function automatic logic [7:0] frame_xor(input logic [7:0] acc, input logic [7:0] data_byte);
        return acc ^ data_byte;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with show-ahead read data, DEPTH a power of two.
module byte_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic [7:0]    wr_data,
    input  logic          pop,
    output logic [7:0]    rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full    = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; occupancy is tracked by the pointers, so stale contents are never read.
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/frame_sender.sv
// Frames buffered result bytes as hdr, len, payload (and checksum when
// FRAME_CHECKSUM_EN is defined) and hands them to a UART transmitter one at a time.
module frame_sender
    import frame_pkg::*;
#(
    parameter int         DEPTH   = 16,
    parameter logic [7:0] IDLE_ID = IDLE_ID_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] state,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       send,
    output logic       full,
    output logic       busy,
    output logic       done,
    input  logic       Tx_busy,
    output logic       Tx_start,
    output logic [7:0] Tx_data
);

    localparam int CW = $clog2(DEPTH) + 1;

    frame_state_t r_state, w_next;
    frame_state_t r_after, w_after_next;
    logic         r_skip;
    logic [7:0]   r_hdr;
    logic [7:0]   r_len;
    logic [7:0]   r_remaining;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]   r_csum;
`endif

    logic          w_idle;
    logic          w_push;
    logic          w_pop;
    logic          w_clear;
    logic          w_accept;
    logic [7:0]    w_len_at_send;
    logic [7:0]    w_rd_data;
    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_empty;
    frame_state_t  w_end_state;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .push    (w_push),
        .wr_data (wr_data),
        .pop     (w_pop),
        .rd_data (w_rd_data),
        .count   (w_fifo_count),
        .full    (full),
        .empty   (w_fifo_empty)
    );

    assign w_idle   = (r_state == ST_IDLE);
    assign w_push   = w_idle && wr_en;
    assign w_accept = w_idle && send && (state != IDLE_ID);
    // A write in the send cycle lands in the buffer first, so it counts toward len
    assign w_len_at_send = 8'(w_fifo_count) + 8'(w_push && !full);
    assign busy = !w_idle;
`ifdef FRAME_CHECKSUM_EN
    assign w_end_state = ST_CHECKSUM;
`else
    assign w_end_state = ST_DONE;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state, byte selection and handshake outputs
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value held (no latches).
        w_next       = r_state;
        w_after_next = r_after;
        Tx_start     = 1'b0;
        Tx_data      = 8'h00;
        w_pop        = 1'b0;
        w_clear      = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_HEADER;
            end
            ST_HEADER: begin
                if (!Tx_busy) begin
                    Tx_start     = 1'b1;
                    Tx_data      = r_hdr;
                    w_next       = ST_WAIT;
                    w_after_next = ST_LENGTH;
                end
            end
            ST_LENGTH: begin
                if (!Tx_busy) begin
                    Tx_start     = 1'b1;
                    Tx_data      = r_len;
                    w_next       = ST_WAIT;
                    w_after_next = (r_len != 8'd0) ? ST_PAYLOAD : w_end_state;
                end
            end
            ST_PAYLOAD: begin
                if (!Tx_busy && !w_fifo_empty) begin
                    Tx_start     = 1'b1;
                    Tx_data      = w_rd_data;
                    w_pop        = 1'b1;
                    w_next       = ST_WAIT;
                    w_after_next = (r_remaining > 8'd1) ? ST_PAYLOAD : w_end_state;
                end
            end
`ifdef FRAME_CHECKSUM_EN
            ST_CHECKSUM: begin
                if (!Tx_busy) begin
                    Tx_start     = 1'b1;
                    Tx_data      = r_csum;
                    w_next       = ST_WAIT;
                    w_after_next = ST_DONE;
                end
            end
`endif
            ST_WAIT: begin
                // The transmitter raises Tx_busy one cycle late, so the first WAIT cycle is ignored
                if (!r_skip && !Tx_busy) w_next = r_after;
            end
            ST_DONE: begin
                done    = 1'b1;
                w_clear = 1'b1;
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Frame context: latched header/length, payload countdown, checksum, WAIT bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_after     <= ST_IDLE;
            r_skip      <= 1'b0;
            r_hdr       <= 8'h00;
            r_len       <= 8'h00;
            r_remaining <= 8'h00;
`ifdef FRAME_CHECKSUM_EN
            r_csum      <= 8'h00;
`endif
        end else begin
            r_after <= w_after_next;
            r_skip  <= Tx_start;
            if (w_accept) begin
                r_hdr       <= state;
                r_len       <= w_len_at_send;
                r_remaining <= w_len_at_send;
`ifdef FRAME_CHECKSUM_EN
                r_csum      <= frame_xor(state, w_len_at_send);
`endif
            end
            if (w_pop) begin
                r_remaining <= r_remaining - 8'd1;
`ifdef FRAME_CHECKSUM_EN
                r_csum      <= frame_xor(r_csum, w_rd_data);
`endif
            end
        end
    end

endmodule

// File: tb/tb_frame_sender.sv
// Bench for frame_sender: queue-based reference model of the frame contents,
// a simple UART transmitter model, and randomized traffic around directed cases.
module tb_frame_sender;

    localparam int         DEPTH   = 16;
    localparam logic [7:0] IDLE_ID = 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] state;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       send;
    logic       full;
    logic       busy;
    logic       done;
    logic       Tx_busy = 1'b0;
    logic       Tx_start;
    logic [7:0] Tx_data;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] model_q[$];   // bytes the buffer should hold
    logic [7:0] cap_q[$];     // bytes seen on the transmit handshake
    int done_cnt    = 0;
    int overlap_cnt = 0;
    int tx_hold     = 1;
    int tx_cnt      = 0;

    frame_sender #(.DEPTH(DEPTH), .IDLE_ID(IDLE_ID)) dut (
        .clk      (clk),
        .reset    (reset),
        .state    (state),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .send     (send),
        .full     (full),
        .busy     (busy),
        .done     (done),
        .Tx_busy  (Tx_busy),
        .Tx_start (Tx_start),
        .Tx_data  (Tx_data)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy from the cycle after a start for tx_hold cycles
    always @(posedge clk) begin
        if (Tx_start) begin
            Tx_busy <= 1'b1;
            tx_cnt  <= tx_hold;
        end else if (tx_cnt > 1) begin
            tx_cnt <= tx_cnt - 1;
        end else begin
            Tx_busy <= 1'b0;
            tx_cnt  <= 0;
        end
    end

    // Mid-cycle monitor of the handshake
    always @(negedge clk) begin
        if (Tx_start) begin
            cap_q.push_back(Tx_data);
            if (Tx_busy) overlap_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(b);
    endtask

    task automatic run_frame(input logic [7:0] hdr, input bit with_wr, input logic [7:0] wr_b,
                             input int hold);
        logic [7:0] exp_q[$];
        logic [7:0] cs;
        bit         got_done;
        tx_hold     = hold;
        cap_q.delete();
        done_cnt    = 0;
        overlap_cnt = 0;
        state   = hdr;
        send    = 1'b1;
        wr_en   = with_wr;
        wr_data = wr_b;
        if (with_wr && model_q.size() < DEPTH) model_q.push_back(wr_b);
        tick();
        send  = 1'b0;
        wr_en = 1'b0;
        if (hdr == IDLE_ID) begin
            check("ignored_busy_now", busy, 0);
            repeat (10) tick();
            check("ignored_busy", busy, 0);
            check("ignored_no_start", cap_q.size(), 0);
            return;
        end
        exp_q.push_back(hdr);
        exp_q.push_back(8'(model_q.size()));
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
`ifdef FRAME_CHECKSUM_EN
        cs = 8'h00;
        foreach (exp_q[i]) cs = cs ^ exp_q[i];
        exp_q.push_back(cs);
`else
        cs = 8'h00;
`endif
        model_q.delete();
        check("busy_rise", busy, 1);
        got_done = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            // Traffic that must be ignored while the frame is in flight
            wr_en   = 1'($urandom);
            wr_data = 8'($urandom);
            send    = 1'($urandom);
            state   = 8'($urandom);
            tick();
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        wr_en = 1'b0;
        send  = 1'b0;
        check("done_seen", got_done, 1);
        check("busy_at_done", busy, 1);
        tick();
        check("busy_after_done", busy, 0);
        check("done_once", done_cnt, 1);
        check("no_start_while_tx_busy", overlap_cnt, 0);
        check("frame_len", cap_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < cap_q.size()) check($sformatf("byte%0d", i), cap_q[i], exp_q[i]);
            else                  check($sformatf("byte%0d_missing", i), 1, 0);
        end
    endtask

    initial begin
        reset   = 1'b1;
        state   = 8'h00;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        send    = 1'b0;
        repeat (3) tick();
        check("rst_tx_start", Tx_start, 0);
        check("rst_tx_data", Tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_full", full, 0);
        reset = 1'b0;
        tick();

        // Basic frame
        write_byte(8'hA1);
        write_byte(8'hB2);
        run_frame(8'h03, 1'b0, 8'h00, 1);

        // Idle header ignored, then an empty frame
        run_frame(8'h00, 1'b0, 8'h00, 1);
        run_frame(8'h05, 1'b0, 8'h00, 1);

        // Overfill: the last two writes are dropped
        for (int i = 0; i < DEPTH + 2; i++) begin
            write_byte(8'(i));
            check($sformatf("full_after_%0d", i + 1), full, model_q.size() == DEPTH);
        end
        run_frame(8'h03, 1'b0, 8'h00, 1);

        // Slow transmitter
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        run_frame(8'h09, 1'b0, 8'h00, 20);

        // Write in the send cycle: counted when space remains, dropped when full
        for (int i = 0; i < DEPTH - 1; i++) write_byte(8'($urandom));
        run_frame(8'h21, 1'b1, 8'h5A, 1);
        for (int i = 0; i < DEPTH; i++) write_byte(8'($urandom));
        run_frame(8'h22, 1'b1, 8'hC3, 2);
        write_byte(8'h7E);
        run_frame(8'h23, 1'b1, 8'h81, 1);

        // Reset after the length byte aborts the frame
        write_byte(8'h44);
        write_byte(8'h55);
        cap_q.delete();
        tx_hold = 3;
        state = 8'h07;
        send  = 1'b1;
        tick();
        send = 1'b0;
        for (int k = 0; k < 500 && cap_q.size() < 2; k++) tick();
        check("abort_len_sent", cap_q.size(), 2);
        reset = 1'b1;
        tick();
        check("abort_tx_start", Tx_start, 0);
        check("abort_busy", busy, 0);
        check("abort_full", full, 0);
        reset = 1'b0;
        model_q.delete();
        repeat (30) tick();
        check("abort_no_more_bytes", cap_q.size(), 2);
        run_frame(8'h04, 1'b0, 8'h00, 1);

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            int n;
            logic [7:0] h;
            n = $urandom_range(0, DEPTH + 4);
            for (int i = 0; i < n; i++) write_byte(8'($urandom));
            h = ($urandom_range(0, 3) == 0) ? IDLE_ID : 8'($urandom_range(1, 255));
            run_frame(h, 1'($urandom), 8'($urandom), $urandom_range(1, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
